// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM state encoding and framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags one cycle per period.
// The registered tick is high on the cycle before the last one, so clients can register period-end actions.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW       = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          tick_r;

    // Next count: held at zero while cleared, wraps after the final cycle of each period
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = {CW{1'b0}};
        end else if (count_r == LAST) begin
            count_next_s = {CW{1'b0}};
        end else begin
            count_next_s = count_r + CW'(1'b1);
        end
    end

    // Counter and early period-end flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tick_r  <= (count_next_s == PRE_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [2:0]           bit_cnt_r;
    logic                 last_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 tick_s;
    logic                 clear_s;

    // The baud counter sits at zero while idle so each frame starts on a fresh period
    assign clear_s = (state_r == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Frame sequencer; last_r marks the final cycle of the current bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= 3'd0;
            last_r    <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    last_r <= 1'b0;
                    done_r <= 1'b0;
                    if (tx_start) begin
                        shift_r   <= tx_data;
                        bit_cnt_r <= 3'd0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= START;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    last_r <= tick_s;
                    if (last_r) begin
                        tx_r    <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        tx_r <= 1'b0;
                    end
                end
                DATA: begin
                    last_r <= tick_s;
                    if (last_r) begin
                        shift_r <= shift_r >> 1;
                        if (bit_cnt_r == LAST_BIT) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            tx_r      <= shift_r[1];
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tx_r <= shift_r[0];
                    end
                end
                STOP: begin
                    // done is raised one edge early so it covers the last stop cycle while still busy
                    last_r <= tick_s;
                    tx_r   <= 1'b1;
                    if (last_r) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done_r <= tick_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    last_r  <= 1'b0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  One clock; reset is asynchronous and active-low.
REQ-004 tx_start  input  1  send request; a one-cycle pulse from the upstream pulse shaper.
REQ-005 tx_data  input  8  byte to send; sampled on the edge that accepts tx_start.
REQ-006 tx  output  1  serial line; idle high, 8N1 framing, LSB first.
REQ-007 tx_busy  output  1  high while a frame is in progress.
REQ-008 tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-009 States: IDLE, START, DATA, STOP; encoding 2 bits; all outputs registered.
REQ-010 IDLE: tx=1, tx_busy=0; tx_start=1 latches tx_data into a shift register, clears the baud and bit counters, and enters START on the same edge.
REQ-011 tx_start while not in IDLE is ignored, with no queuing and no effect on the frame in progress.
REQ-012 Latency: tx falls on the first rising edge after the edge that samples tx_start=1 (one registered cycle).
REQ-013 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-014 DATA: tx = shift register bit 0 for CLKS_PER_BIT cycles per bit; shift right once per bit; 3-bit bit counter 0..7; after bit 7 completes, enter STOP.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles; on the final cycle, return to IDLE and assert tx_done for exactly one cycle.
REQ-016 Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); the bit-period end is count == CLKS_PER_BIT-1; the counter wraps to 0 and never overflows.
REQ-017 tx_busy = 1 in START, DATA and STOP, including the cycle in which tx_done is high.
REQ-018 Frame length on the line is exactly 10*CLKS_PER_BIT cycles of tx activity (start + 8 data + stop).
REQ-019 tx_start asserted in the same cycle as tx_done is ignored (state not yet IDLE).
REQ-020 tx_start in the first IDLE cycle after done is accepted; minimum frame-to-frame spacing is 10*CLKS_PER_BIT+1 cycles.
REQ-021 Changes on tx_data after acceptance do not affect the frame in progress.

Reset
REQ-022 rst_n=0 forces asynchronously: state=IDLE, tx=1, tx_busy=0, tx_done=0, and all counters and the shift register to 0.
REQ-023 Reset mid-frame aborts the frame; tx returns high immediately with no tx_done pulse.
REQ-024 After rst_n deasserts, the first tx_start is accepted per REQ-010.

Structure
REQ-025 Shared package uart_pkg holds: the state typedef/encodings (IDLE, START, DATA, STOP); DEFAULT_CLKS_PER_BIT; DATA_BITS=8.
REQ-026 One sub-module, uart_baud_tick, provides the parameterised bit-period counter: inputs clk, rst_n, clear; output tick (one cycle per CLKS_PER_BIT).
REQ-027 uart_baud_tick is reused unchanged by the future uart_rx.
REQ-028 No other hierarchy.

Verification (CLKS_PER_BIT=4)
REQ-029 tx_start pulse with tx_data=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done high once at cycle 40 after the first low; tx_busy high for 40 cycles.
REQ-030 tx_data=8'h00 then 8'hFF, started back-to-back at the earliest legal cycle -> two correct frames with a 1-cycle idle high between them.
REQ-031 tx_start pulsed mid-frame (DATA, bit 3) with a different tx_data -> original frame unchanged, no second frame, one tx_done.
REQ-032 rst_n low during STOP -> tx=1, tx_busy=0 within the same cycle, no tx_done; the next tx_start with 8'h3C sends a correct frame.
REQ-033 tx_start held high 3 cycles -> exactly one frame; tx_start coincident with tx_done -> ignored.
